// File: rtl/axi_rdma_mb_pkg.sv
// axi_rdma_mb_pkg: shared response codes, FSM states and lane-mask helpers for the read DMA
package rdma_pkg;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_STS} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [15:0] keep_first(input logic [3:0] off);
    return 16'hffff << off;
  endfunction
  function automatic logic [15:0] keep_last(input logic [3:0] end_off);
    return 16'hffff >> (4'd15 - end_off);
  endfunction
endpackage

// File: rtl/axi_rdma_mb_if.sv
// axi_rdma_mb_if: command/status, AXI4 read channels and output stream of the read DMA
interface axi_rdma_mb_if #(
  parameter int ADDRESS_BITS = 32,
  parameter int LENGTH_BITS = 32,
  parameter int DATA_BYTES = 4
);
  logic [ADDRESS_BITS-1:0] cmd_address;
  logic [LENGTH_BITS-1:0] cmd_bytes;
  logic cmd_valid, cmd_ready;
  logic [1:0] sts_resp;
  logic sts_valid, sts_ready;
  logic [3:0] axi_m_arid;
  logic [ADDRESS_BITS-1:0] axi_m_araddr;
  logic [7:0] axi_m_arlen;
  logic [2:0] axi_m_arsize;
  logic [1:0] axi_m_arburst;
  logic axi_m_arvalid, axi_m_arready;
  logic [3:0] axi_m_rid;
  logic [8*DATA_BYTES-1:0] axi_m_rdata;
  logic [1:0] axi_m_rresp;
  logic axi_m_rlast, axi_m_rvalid, axi_m_rready;
  logic [8*DATA_BYTES-1:0] dout_tdata;
  logic [DATA_BYTES-1:0] dout_tkeep;
  logic dout_tlast, dout_tvalid, dout_tready;
  modport master (
    input cmd_address, cmd_bytes, cmd_valid, sts_ready, axi_m_arready,
          axi_m_rid, axi_m_rdata, axi_m_rresp, axi_m_rlast, axi_m_rvalid, dout_tready,
    output cmd_ready, sts_resp, sts_valid, axi_m_arid, axi_m_araddr, axi_m_arlen,
           axi_m_arsize, axi_m_arburst, axi_m_arvalid, axi_m_rready,
           dout_tdata, dout_tkeep, dout_tlast, dout_tvalid
  );
  modport slave (
    output cmd_address, cmd_bytes, cmd_valid, sts_ready, axi_m_arready,
           axi_m_rid, axi_m_rdata, axi_m_rresp, axi_m_rlast, axi_m_rvalid, dout_tready,
    input cmd_ready, sts_resp, sts_valid, axi_m_arid, axi_m_araddr, axi_m_arlen,
          axi_m_arsize, axi_m_arburst, axi_m_arvalid, axi_m_rready,
          dout_tdata, dout_tkeep, dout_tlast, dout_tvalid
  );
endinterface

// File: rtl/axi_rdma_mb_burst_calc.sv
// rdma_burst_calc: beats for the next AR, limited by remaining beats, MAX_BURST and the 4 KiB page end
module rdma_burst_calc
  import rdma_pkg::*;
#(
  parameter int LENGTH_BITS = 32,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST = 256
) (
  input logic [11:0] addr_lo,
  input logic [LENGTH_BITS-1:0] remaining,
  output logic [LENGTH_BITS-1:0] burst
);
  localparam int LG = clog2(DATA_BYTES);
  logic [12:0] room;
  logic [LENGTH_BITS-1:0] cap;
  always_comb begin
    room = (13'd4096 - {1'b0, addr_lo}) >> LG;
    cap = room < 13'(MAX_BURST) ? LENGTH_BITS'(room) : LENGTH_BITS'(MAX_BURST);
    burst = remaining < cap ? remaining : cap;
  end
endmodule

// File: rtl/axi_rdma_mb.sv
// axi_rdma_mb: AXI4 read DMA streaming cmd_bytes from cmd_address as one packet,
// with multiple outstanding bursts, 4 KiB splitting and worst-RRESP completion status
module axi_rdma_mb
  import rdma_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int LENGTH_BITS = 32,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_ID = 0
) (
  input logic aclk,
  input logic aresetn,
  axi_rdma_mb_if.master bus
);
  localparam int LG = clog2(DATA_BYTES);
  state_t state, state_n;
  logic [ADDRESS_BITS-1:0] next_addr;
  logic [LENGTH_BITS-1:0] remaining, beats, beats_in, dout_beats, burst;
  logic [LENGTH_BITS:0] span;
  logic [3:0] off, in_off, end_off, outstanding;
  logic [15:0] kf, kl;
  logic [1:0] sts_q;
  logic active, last_beat, cmd_hs, ar_hs, r_hs, sts_hs;
  rdma_burst_calc #(.LENGTH_BITS(LENGTH_BITS), .DATA_BYTES(DATA_BYTES), .MAX_BURST(MAX_BURST)) u_calc (
    .addr_lo(next_addr[11:0]),
    .remaining(remaining),
    .burst(burst)
  );
  assign in_off = 4'(bus.cmd_address[LG-1:0]);
  assign span = {1'b0, bus.cmd_bytes} + (LENGTH_BITS+1)'(in_off) + (LENGTH_BITS+1)'(DATA_BYTES - 1);
  assign beats_in = LENGTH_BITS'(span >> LG);
  assign active = state == S_ADDR || state == S_DRAIN;
  assign last_beat = dout_beats == beats - 1'b1;
  assign kf = keep_first(off);
  assign kl = keep_last(end_off);
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.sts_valid = state == S_STS;
  assign bus.sts_resp = sts_q;
  assign bus.axi_m_arid = 4'(AXI_ID);
  assign bus.axi_m_araddr = next_addr;
  assign bus.axi_m_arlen = 8'(burst - 1'b1);
  assign bus.axi_m_arsize = 3'(LG);
  assign bus.axi_m_arburst = BURST_INCR;
  assign bus.axi_m_arvalid = state == S_ADDR && outstanding < 4'(MAX_OUTSTANDING);
  assign bus.axi_m_rready = active & bus.dout_tready;
  assign bus.dout_tvalid = active & bus.axi_m_rvalid;
  assign bus.dout_tdata = bus.axi_m_rdata;
  assign bus.dout_tkeep = (dout_beats == '0 ? kf[DATA_BYTES-1:0] : '1) & (last_beat ? kl[DATA_BYTES-1:0] : '1);
  assign bus.dout_tlast = last_beat;
  assign cmd_hs = bus.cmd_valid & bus.cmd_ready;
  assign ar_hs = bus.axi_m_arvalid & bus.axi_m_arready;
  assign r_hs = bus.axi_m_rvalid & bus.axi_m_rready;
  assign sts_hs = bus.sts_valid & bus.sts_ready;
  always_comb begin
    state_n = state;
    if (cmd_hs) state_n = bus.cmd_bytes == '0 ? S_STS : S_ADDR;
    if (state == S_ADDR && ar_hs && remaining == burst) state_n = S_DRAIN;
    if (state == S_DRAIN && r_hs && last_beat) state_n = S_STS;
    if (sts_hs) state_n = S_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= S_IDLE;
      next_addr <= '0;
      remaining <= '0;
      beats <= '0;
      dout_beats <= '0;
      off <= '0;
      end_off <= '0;
      outstanding <= '0;
      sts_q <= RESP_OKAY;
    end else begin
      state <= state_n;
      outstanding <= outstanding + 4'(ar_hs) - 4'(r_hs & bus.axi_m_rlast);
      if (cmd_hs) begin
        next_addr <= {bus.cmd_address[ADDRESS_BITS-1:LG], LG'(0)};
        remaining <= beats_in;
        beats <= beats_in;
        dout_beats <= '0;
        off <= in_off;
        end_off <= 4'(LG'(bus.cmd_address[LG-1:0] + bus.cmd_bytes[LG-1:0] - 1'b1));
        sts_q <= RESP_OKAY;
      end
      if (ar_hs) begin
        next_addr <= next_addr + (ADDRESS_BITS'(burst) << LG);
        remaining <= remaining - burst;
      end
      if (r_hs) begin
        dout_beats <= dout_beats + 1'b1;
        if (bus.axi_m_rresp > sts_q) sts_q <= bus.axi_m_rresp;
      end
    end
endmodule

// File: tb/tb_axi_rdma_mb.sv
// tb_axi_rdma_mb: directed and random commands against a randomly stalling AXI slave,
// compared with a byte-level model of the expected bursts, stream and status
module tb_axi_rdma_mb;
  import rdma_pkg::*;
  localparam int DB = 4;
  localparam int MB = 16;
  localparam int MO = 2;
  typedef struct {longint addr; int len;} ar_t;
  typedef struct packed {logic [8*DB-1:0] data; logic [DB-1:0] keep; logic last; logic valid;} beat_t;
  logic aclk = 0;
  logic aresetn = 0;
  always #5 aclk = ~aclk;
  axi_rdma_mb_if #(.ADDRESS_BITS(32), .LENGTH_BITS(32), .DATA_BYTES(DB)) bus ();
  axi_rdma_mb #(.ADDRESS_BITS(32), .LENGTH_BITS(32), .DATA_BYTES(DB), .MAX_BURST(MB),
                .MAX_OUTSTANDING(MO), .AXI_ID(0)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  ar_t ar_q[$], obs_ar[$], exp_ar[$];
  beat_t obs_beat[$], exp_beat[$];
  int total = 0, bad = 0;
  int ar_pct = 60, r_pct = 60, t_pct = 70;
  bit r_stall = 0, r_hs = 0;
  int err_beat = -1, slv_beat = 0, r_idx = 0;
  logic [1:0] err_code = RESP_OKAY;

  function automatic logic [7:0] mem(input longint a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI read slave: random arready/rvalid, in-order data from mem(), optional injected error beat
  always @(negedge aclk) begin
    if (!aresetn) begin
      ar_q.delete();
      r_idx = 0;
      r_hs = 0;
      bus.axi_m_rvalid = 0;
      bus.axi_m_arready = 0;
      bus.dout_tready = 0;
      bus.axi_m_rid = 0;
      bus.axi_m_rlast = 0;
      bus.axi_m_rresp = RESP_OKAY;
      bus.axi_m_rdata = '0;
    end else begin
      if (r_hs) bus.axi_m_rvalid = 0;
      r_hs = 0;
      bus.axi_m_arready = $urandom_range(99) < ar_pct;
      bus.dout_tready = $urandom_range(99) < t_pct;
      if (!bus.axi_m_rvalid && ar_q.size() != 0 && !r_stall && $urandom_range(99) < r_pct) begin
        for (int l = 0; l < DB; l++) bus.axi_m_rdata[8*l+:8] = mem(ar_q[0].addr + longint'(r_idx * DB + l));
        bus.axi_m_rlast = r_idx == ar_q[0].len;
        bus.axi_m_rresp = slv_beat == err_beat ? err_code : RESP_OKAY;
        bus.axi_m_rvalid = 1;
      end
    end
    #4;
    if (aresetn) begin
      if (bus.axi_m_arvalid && bus.axi_m_arready) begin
        ar_q.push_back('{longint'(bus.axi_m_araddr), int'(bus.axi_m_arlen)});
        obs_ar.push_back('{longint'(bus.axi_m_araddr), int'(bus.axi_m_arlen)});
      end
      if (bus.axi_m_rvalid && bus.axi_m_rready) begin
        obs_beat.push_back({bus.dout_tdata, bus.dout_tkeep, bus.dout_tlast, bus.dout_tvalid});
        slv_beat++;
        r_hs = 1;
        if (bus.axi_m_rlast) begin
          void'(ar_q.pop_front());
          r_idx = 0;
        end else r_idx++;
      end
    end
  end

  task automatic build_exp(input longint addr, input longint nbytes, input int eb, input logic [1:0] ec,
                           output logic [1:0] exp_resp);
    longint base = addr - addr % DB;
    longint nb = (addr % DB + nbytes + DB - 1) / DB;
    longint a = base;
    longint rem = nb;
    exp_ar.delete();
    exp_beat.delete();
    while (rem > 0) begin
      longint b = rem;
      longint room = (4096 - a % 4096) / DB;
      if (b > MB) b = MB;
      if (b > room) b = room;
      exp_ar.push_back('{a, int'(b - 1)});
      a += b * DB;
      rem -= b;
    end
    for (longint i = 0; i < nb; i++) begin
      beat_t e;
      for (int l = 0; l < DB; l++) begin
        longint ba = base + i * DB + l;
        e.data[8*l+:8] = mem(ba);
        e.keep[l] = ba >= addr && ba < addr + nbytes;
      end
      e.last = i == nb - 1;
      e.valid = 1;
      exp_beat.push_back(e);
    end
    exp_resp = (eb >= 0 && eb < nb) ? ec : RESP_OKAY;
  endtask

  task automatic start_cmd(input string tag, input longint addr, input longint nbytes, input int eb,
                           input logic [1:0] ec);
    int n;
    obs_ar.delete();
    obs_beat.delete();
    err_beat = eb;
    err_code = ec;
    slv_beat = 0;
    @(negedge aclk);
    bus.cmd_address = 32'(addr);
    bus.cmd_bytes = 32'(nbytes);
    bus.cmd_valid = 1;
    for (n = 0; n < 200; n++) begin
      #4;
      if (bus.cmd_ready) break;
      @(negedge aclk);
    end
    chk($sformatf("%s_cmd_accept", tag), 64'(n < 200), 1);
    @(negedge aclk);
    bus.cmd_valid = 0;
    #4;
    chk($sformatf("%s_busy", tag), 64'(bus.cmd_ready), 0);
  endtask

  task automatic finish_cmd(input string tag, input logic [1:0] exp_resp);
    bit got = 0;
    logic [1:0] resp = 2'bxx;
    for (int n = 0; n < 30000; n++) begin
      @(negedge aclk);
      bus.sts_ready = 1'($urandom_range(1));
      #4;
      if (bus.sts_valid && bus.sts_ready) begin
        got = 1;
        resp = bus.sts_resp;
        break;
      end
    end
    chk($sformatf("%s_sts_seen", tag), 64'(got), 1);
    @(negedge aclk);
    bus.sts_ready = 0;
    #4;
    chk($sformatf("%s_ready_again", tag), 64'(bus.cmd_ready), 1);
    chk($sformatf("%s_sts_resp", tag), 64'(resp), 64'(exp_resp));
    chk($sformatf("%s_ar_n", tag), 64'(obs_ar.size()), 64'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < obs_ar.size(); i++) begin
      chk($sformatf("%s_araddr%0d", tag, i), 64'(obs_ar[i].addr), 64'(exp_ar[i].addr));
      chk($sformatf("%s_arlen%0d", tag, i), 64'(obs_ar[i].len), 64'(exp_ar[i].len));
    end
    chk($sformatf("%s_beat_n", tag), 64'(obs_beat.size()), 64'(exp_beat.size()));
    for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(obs_beat[i]), 64'(exp_beat[i]));
  endtask

  task automatic do_cmd(input string tag, input longint addr, input longint nbytes, input int eb,
                        input logic [1:0] ec);
    logic [1:0] er;
    build_exp(addr, nbytes, eb, ec, er);
    start_cmd(tag, addr, nbytes, eb, ec);
    finish_cmd(tag, er);
  endtask

  initial begin
    logic [1:0] er;
    bit prog;
    bus.cmd_valid = 0;
    bus.cmd_address = 0;
    bus.cmd_bytes = 0;
    bus.sts_ready = 0;
    repeat (3) @(negedge aclk);
    #4;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rst_arvalid", 64'(bus.axi_m_arvalid), 0);
    chk("rst_sts_valid", 64'(bus.sts_valid), 0);
    chk("rst_sts_resp", 64'(bus.sts_resp), 0);
    chk("arsize", 64'(bus.axi_m_arsize), 2);
    chk("arburst", 64'(bus.axi_m_arburst), 1);
    chk("arid", 64'(bus.axi_m_arid), 0);
    @(negedge aclk);
    aresetn = 1;
    do_cmd("t1", 64'h1001, 6, -1, RESP_OKAY);
    do_cmd("t2", 64'h0ff8, 32, -1, RESP_OKAY);
    // zero-length: status on the very next cycle, held while sts_ready is low
    build_exp(64'h40, 0, -1, RESP_OKAY, er);
    start_cmd("t4", 64'h40, 0, -1, RESP_OKAY);
    chk("t4_sts_next", 64'(bus.sts_valid), 1);
    repeat (3) @(negedge aclk);
    #4;
    chk("t4_sts_hold", 64'(bus.sts_valid), 1);
    chk("t4_ready_hold", 64'(bus.cmd_ready), 0);
    finish_cmd("t4", er);
    do_cmd("t5", 64'h200, 32, 3, RESP_SLVERR);
    // stalled read data: only MAX_OUTSTANDING bursts may be issued
    ar_pct = 100;
    r_stall = 1;
    build_exp(0, 4096, -1, RESP_OKAY, er);
    start_cmd("t3", 0, 4096, -1, RESP_OKAY);
    repeat (20) @(negedge aclk);
    #2;
    chk("t3_ar_stalled", 64'(obs_ar.size()), MO);
    chk("t3_arvalid_gated", 64'(bus.axi_m_arvalid), 0);
    r_stall = 0;
    ar_pct = 60;
    finish_cmd("t3", er);
    // reset while draining
    build_exp(64'h300, 40, -1, RESP_OKAY, er);
    start_cmd("t6", 64'h300, 40, -1, RESP_OKAY);
    prog = 0;
    for (int n = 0; n < 2000 && !prog; n++) begin
      @(negedge aclk);
      #2;
      prog = obs_beat.size() >= 3;
    end
    chk("t6_progress", 64'(prog), 1);
    #1 aresetn = 0;
    #1;
    chk("t6_cmd_ready", 64'(bus.cmd_ready), 1);
    chk("t6_arvalid", 64'(bus.axi_m_arvalid), 0);
    chk("t6_sts_valid", 64'(bus.sts_valid), 0);
    chk("t6_sts_resp", 64'(bus.sts_resp), 0);
    chk("t6_tvalid", 64'(bus.dout_tvalid), 0);
    chk("t6_rready", 64'(bus.axi_m_rready), 0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    do_cmd("t6_after", 64'h1003, 57, -1, RESP_OKAY);
    for (int k = 0; k < 10; k++) begin
      longint addr = (k % 2) ? longint'(4096 * (k + 1) - $urandom_range(1, 80)) : longint'($urandom_range(0, 20000));
      longint nbytes = longint'($urandom_range(0, 200));
      int eb = $urandom_range(1) ? int'($urandom_range(0, 60)) : -1;
      do_cmd($sformatf("rnd%0d", k), addr, nbytes, eb, 2'($urandom_range(3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
